cdc_handshake_arbiter: RTL

Source-domain (clk_A) controller that shares one single-bit 2-FF CDC channel among N_REQ requesters. It runs a four-phase level handshake on the channel: it drives the channel's IN and watches an acknowledge that domain B returns through a second synchronizer. It grants round-robin and reports completion per requester. It sits between clk_A-domain event sources and the cdc_synchronizer pair, so no requester ever drives the synchronizer directly.

---
 rtl/cdc_handshake_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/cdc_handshake_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdc_handshake_arbiter
// Description : Source-domain (clk_A) controller that shares one single-bit
//               2-FF CDC channel among N_REQ requesters. It runs a four-phase
//               level handshake: raise sync_out, wait for the synchronized
//               acknowledge to rise, drop sync_out, wait for the acknowledge
//               to fall, then pulse grant for the served requester. The
//               requesters are served in round-robin order.
// Optional    : `define CDC_ARB_TIMEOUT_EN adds a wait-state watchdog. If a
//               handshake phase lasts TIMEOUT cycles, the transfer is
//               abandoned and the sticky err flag is set. Without the macro,
//               err is tied low and err_clr is ignored.
// Ports       : clk_A    - source-domain clock
//               reset    - asynchronous reset, active low
//               req      - per-requester level transfer request
//               ack_sync - acknowledge from domain B, already synchronized
//               sync_out - drives IN of the CDC synchronizer
//               grant    - one-hot, single-cycle completion pulse
//               owner    - index of the requester being (or last) served
//               busy     - high whenever a handshake is in progress
//               err      - sticky timeout flag (optional feature)
//               err_clr  - clears err (optional feature)
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_handshake_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic             clk_A,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             ack_sync,
    output logic             sync_out,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  owner,
    output logic             busy,
    output logic             err,
    input  logic             err_clr
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        WAIT_LO = 2'd2
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   winner;
    logic              found;
    logic [ID_W-1:0]   next_ptr;
    logic [N_REQ-1:0]  owner_onehot;

    // Round-robin pick: first set request at or above rr_ptr, wrapping.
    always_comb begin
        winner = rr_ptr;
        found  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            int unsigned idx;
            idx = (int'(rr_ptr) + i) % N_REQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    // The requester just served gets lowest priority next time.
    assign next_ptr     = (owner == ID_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
    assign owner_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << owner;

`ifdef CDC_ARB_TIMEOUT_EN
    localparam int             CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    // Number of cycles already spent in the current wait state.
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk_A or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            sync_out <= 1'b0;
            grant    <= '0;
            owner    <= '0;
            busy     <= 1'b0;
            rr_ptr   <= '0;
            err      <= 1'b0;
            wait_cnt <= '0;
        end else begin
            grant <= '0;
            // A timeout later in this block overrides the clear.
            if (err_clr) begin
                err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    // A still-high acknowledge (stale from before a reset)
                    // blocks any new start until domain B releases it.
                    if (found && !ack_sync) begin
                        owner    <= winner;
                        sync_out <= 1'b1;
                        busy     <= 1'b1;
                        wait_cnt <= '0;
                        state    <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (ack_sync) begin
                        sync_out <= 1'b0;
                        wait_cnt <= '0;
                        state    <= WAIT_LO;
                    end else if (wait_cnt == TO_LAST) begin
                        sync_out <= 1'b0;
                        err      <= 1'b1;
                        busy     <= 1'b0;
                        rr_ptr   <= next_ptr;
                        state    <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (!ack_sync) begin
                        grant  <= owner_onehot;
                        rr_ptr <= next_ptr;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else if (wait_cnt == TO_LAST) begin
                        sync_out <= 1'b0;
                        err      <= 1'b1;
                        busy     <= 1'b0;
                        rr_ptr   <= next_ptr;
                        state    <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    sync_out <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
`else
    // Without the watchdog the error path does not exist.
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err            = 1'b0;

    always_ff @(posedge clk_A or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            sync_out <= 1'b0;
            grant    <= '0;
            owner    <= '0;
            busy     <= 1'b0;
            rr_ptr   <= '0;
        end else begin
            grant <= '0;
            case (state)
                IDLE: begin
                    // A still-high acknowledge (stale from before a reset)
                    // blocks any new start until domain B releases it.
                    if (found && !ack_sync) begin
                        owner    <= winner;
                        sync_out <= 1'b1;
                        busy     <= 1'b1;
                        state    <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (ack_sync) begin
                        sync_out <= 1'b0;
                        state    <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (!ack_sync) begin
                        grant  <= owner_onehot;
                        rr_ptr <= next_ptr;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    sync_out <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
`endif

endmodule
`default_nettype wire
